// File: rtl/rtc_time_uart_tx.sv
// -----------------------------------------------------------------------------
// rtc_time_uart_tx
//
// Serial time reporter for the RTC. A single-cycle request on send snapshots
// the six BCD time digits and transmits the line "HH:MM:SS\r\n" over a UART
// TX line, LSB first, one start bit and one stop bit per byte.
//
// Optional feature (compile-time macro RTC_UART_PARITY_EN):
//   undefined : 8N1 frames, 10 bits per byte.
//   defined   : 8E1 frames, an even-parity bit follows the 8 data bits.
//
// Parameters:
//   CLK_HZ       - input clock frequency in Hz
//   BAUD         - line rate in bit/s
//   CLKS_PER_BIT - clocks per UART bit (>= 2), CLK_HZ/BAUD by default
//
// Ports:
//   clk   - system clock
//   rst   - asynchronous, active-low reset
//   send  - single-cycle request to transmit one time line
//   hr1   - hours tens digit (BCD)
//   hr0   - hours units digit
//   min1  - minutes tens digit
//   min0  - minutes units digit
//   sec1  - seconds tens digit
//   sec0  - seconds units digit
//   txd   - UART serial out, idle high
//   busy  - high while a line is in progress
//   done  - one-cycle pulse when a line completes
// -----------------------------------------------------------------------------
module rtc_time_uart_tx #(
   parameter int CLK_HZ       = 50000000,
   parameter int BAUD         = 115200,
   parameter int CLKS_PER_BIT = CLK_HZ / BAUD
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       send,
   input  logic [1:0] hr1,
   input  logic [3:0] hr0,
   input  logic [2:0] min1,
   input  logic [3:0] min0,
   input  logic [2:0] sec1,
   input  logic [3:0] sec0,
   output logic       txd,
   output logic       busy,
   output logic       done
);

   localparam int            CW       = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
   localparam logic [3:0]    LAST_BYTE = 4'd9;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
`ifdef RTC_UART_PARITY_EN
      PARITY = 3'd3,
`endif
      STOP   = 3'd4
   } state_t;

   state_t        state, state_nxt;
   logic [CW-1:0] cnt, cnt_nxt;
   logic [2:0]    bit_idx, bit_nxt;
   logic [3:0]    byte_idx, byte_nxt;
   logic          txd_nxt, busy_nxt, done_nxt;
   logic          capture;
   logic          bit_end;
   logic [7:0]    cur_byte;

   // Digit snapshot, frozen for the whole line.
   logic [1:0]    snap_hr1;
   logic [3:0]    snap_hr0;
   logic [2:0]    snap_min1;
   logic [3:0]    snap_min0;
   logic [2:0]    snap_sec1;
   logic [3:0]    snap_sec0;

   // ASCII digit, or '?' for anything outside 0..9.
   function automatic logic [7:0] to_ascii(input logic [3:0] d);
      return (d > 4'd9) ? 8'h3F : {4'h3, d};
   endfunction

   always_comb begin
      case (byte_idx)
         4'd0:    cur_byte = to_ascii({2'b00, snap_hr1});
         4'd1:    cur_byte = to_ascii(snap_hr0);
         4'd2:    cur_byte = 8'h3A;
         4'd3:    cur_byte = to_ascii({1'b0, snap_min1});
         4'd4:    cur_byte = to_ascii(snap_min0);
         4'd5:    cur_byte = 8'h3A;
         4'd6:    cur_byte = to_ascii({1'b0, snap_sec1});
         4'd7:    cur_byte = to_ascii(snap_sec0);
         4'd8:    cur_byte = 8'h0D;
         default: cur_byte = 8'h0A;
      endcase
   end

   assign bit_end = (cnt == CNT_LAST);

   // Next-state and next-output logic. txd/busy/done are computed here one
   // cycle ahead and registered, so every output changes on the clock edge
   // that makes the corresponding state transition.
   always_comb begin
      // NOTE: every signal gets a default first so no path leaves it unassigned,
      // which would otherwise infer a latch.
      state_nxt = state;
      cnt_nxt   = cnt;
      bit_nxt   = bit_idx;
      byte_nxt  = byte_idx;
      txd_nxt   = txd;
      busy_nxt  = busy;
      done_nxt  = 1'b0;
      capture   = 1'b0;

      if (state != IDLE) begin
         cnt_nxt = bit_end ? '0 : cnt + 1'b1;
      end

      case (state)
         IDLE: begin
            if (send) begin
               capture   = 1'b1;
               state_nxt = START;
               cnt_nxt   = '0;
               byte_nxt  = '0;
               txd_nxt   = 1'b0;
               busy_nxt  = 1'b1;
            end
         end
         START: begin
            if (bit_end) begin
               state_nxt = DATA;
               bit_nxt   = '0;
               txd_nxt   = cur_byte[0];
            end
         end
         DATA: begin
            if (bit_end) begin
               if (bit_idx == 3'd7) begin
`ifdef RTC_UART_PARITY_EN
                  state_nxt = PARITY;
                  txd_nxt   = ^cur_byte;
`else
                  state_nxt = STOP;
                  txd_nxt   = 1'b1;
`endif
               end else begin
                  bit_nxt = bit_idx + 3'd1;
                  txd_nxt = cur_byte[bit_idx + 3'd1];
               end
            end
         end
`ifdef RTC_UART_PARITY_EN
         PARITY: begin
            if (bit_end) begin
               state_nxt = STOP;
               txd_nxt   = 1'b1;
            end
         end
`endif
         STOP: begin
            if (bit_end) begin
               if (byte_idx == LAST_BYTE) begin
                  state_nxt = IDLE;
                  txd_nxt   = 1'b1;
                  busy_nxt  = 1'b0;
                  done_nxt  = 1'b1;
               end else begin
                  // Back-to-back bytes: next start bit follows the stop bit directly.
                  state_nxt = START;
                  byte_nxt  = byte_idx + 4'd1;
                  txd_nxt   = 1'b0;
               end
            end
         end
         default: begin
            state_nxt = IDLE;
            txd_nxt   = 1'b1;
            busy_nxt  = 1'b0;
         end
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so all registers
   // update together from values sampled before the edge.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state    <= IDLE;
         cnt      <= '0;
         bit_idx  <= '0;
         byte_idx <= '0;
         txd      <= 1'b1;
         busy     <= 1'b0;
         done     <= 1'b0;
      end else begin
         state    <= state_nxt;
         cnt      <= cnt_nxt;
         bit_idx  <= bit_nxt;
         byte_idx <= byte_nxt;
         txd      <= txd_nxt;
         busy     <= busy_nxt;
         done     <= done_nxt;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         snap_hr1  <= '0;
         snap_hr0  <= '0;
         snap_min1 <= '0;
         snap_min0 <= '0;
         snap_sec1 <= '0;
         snap_sec0 <= '0;
      end else if (capture) begin
         snap_hr1  <= hr1;
         snap_hr0  <= hr0;
         snap_min1 <= min1;
         snap_min0 <= min0;
         snap_sec1 <= sec1;
         snap_sec0 <= sec0;
      end
   end

endmodule

// File: tb/tb_rtc_time_uart_tx.sv
// -----------------------------------------------------------------------------
// tb_rtc_time_uart_tx
//
// Self-checking bench for rtc_time_uart_tx. The main instance runs with a
// short bit period so several whole lines fit in a short run; a second
// instance at default parameters checks the real 434-clock bit time.
// Expected bytes are pushed to a queue when a request is accepted; a UART
// receiver model decodes txd and the decoded bytes are compared against the
// queue once the line completes. Honours RTC_UART_PARITY_EN.
// -----------------------------------------------------------------------------
module tb_rtc_time_uart_tx;

   localparam int CPB = 16;
`ifdef RTC_UART_PARITY_EN
   localparam int BITS = 11;
`else
   localparam int BITS = 10;
`endif
   localparam int LINE = 10 * BITS * CPB;

   typedef struct {
      logic [7:0] data;
      logic       start;
      logic       par;
      logic       stop;
   } rx_t;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       send = 1'b0;
   logic       send_def = 1'b0;
   logic [1:0] hr1 = '0;
   logic [3:0] hr0 = '0;
   logic [2:0] min1 = '0;
   logic [3:0] min0 = '0;
   logic [2:0] sec1 = '0;
   logic [3:0] sec0 = '0;
   logic       txd, busy, done;
   logic       txd_def, busy_def, done_def;

   int         tests = 0;
   int         fails = 0;
   logic [7:0] exp_q[$];
   rx_t        rx_q[$];
   int         rd_ptr = 0;
   int         done_count = 0;

   rtc_time_uart_tx #(.CLKS_PER_BIT(CPB)) dut (
      .clk(clk), .rst(rst), .send(send),
      .hr1(hr1), .hr0(hr0), .min1(min1), .min0(min0), .sec1(sec1), .sec0(sec0),
      .txd(txd), .busy(busy), .done(done)
   );

   rtc_time_uart_tx dut_def (
      .clk(clk), .rst(rst), .send(send_def),
      .hr1(hr1), .hr0(hr0), .min1(min1), .min0(min0), .sec1(sec1), .sec0(sec0),
      .txd(txd_def), .busy(busy_def), .done(done_def)
   );

   always #5 clk = ~clk;

   // UART receiver model: samples each bit in its middle on the falling edge.
   logic       rx_active = 1'b0;
   int         rx_cnt = 0;
   rx_t        rx_cur;
   always @(negedge clk) begin
      if (!rst) begin
         rx_active = 1'b0;
      end else if (!rx_active) begin
         if (txd === 1'b0) begin
            rx_active = 1'b1;
            rx_cnt    = 0;
            rx_cur    = '{data: 8'h00, start: 1'b1, par: 1'b0, stop: 1'b0};
         end
      end else begin
         rx_cnt++;
         if (rx_cnt % CPB == CPB / 2) begin
            int j;
            j = rx_cnt / CPB;
            if (j == 0) rx_cur.start = txd;
            else if (j <= 8) rx_cur.data[j-1] = txd;
            else if (j == BITS - 1) begin
               rx_cur.stop = txd;
               rx_q.push_back(rx_cur);
               rx_active = 1'b0;
            end else rx_cur.par = txd;
         end
      end
   end

   always @(negedge clk) begin
      if (rst && done === 1'b1) done_count++;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [7:0] model_ascii(input int d);
      return (d <= 9) ? 8'(8'h30 + d) : 8'h3F;
   endfunction

   task automatic set_digits(input int a, input int b, input int c, input int d, input int e, input int f);
      hr1 = 2'(a); hr0 = 4'(b); min1 = 3'(c); min0 = 4'(d); sec1 = 3'(e); sec0 = 4'(f);
   endtask

   // Pulse send for one cycle and record the expected line.
   task automatic send_line(input int a, input int b, input int c, input int d, input int e, input int f);
      set_digits(a, b, c, d, e, f);
      exp_q.push_back(model_ascii(a));
      exp_q.push_back(model_ascii(b));
      exp_q.push_back(8'h3A);
      exp_q.push_back(model_ascii(c));
      exp_q.push_back(model_ascii(d));
      exp_q.push_back(8'h3A);
      exp_q.push_back(model_ascii(e));
      exp_q.push_back(model_ascii(f));
      exp_q.push_back(8'h0D);
      exp_q.push_back(8'h0A);
      send = 1'b1;
      tick();
      send = 1'b0;
   endtask

   // Wait for done with a cycle budget; start = cycles already elapsed since acceptance.
   task automatic wait_done(input string tag, input int start);
      int cycles;
      int seen;
      int busy_drop;
      cycles = start; seen = 0; busy_drop = 0;
      while (cycles < LINE + 4 * CPB) begin
         if (done === 1'b1) begin
            seen = 1;
            break;
         end
         if (busy !== 1'b1) busy_drop++;
         tick();
         cycles++;
      end
      check({tag, " done seen"}, seen, 1);
      check({tag, " line clocks"}, cycles, LINE);
      check({tag, " busy held"}, busy_drop, 0);
      tick();
      check({tag, " done single"}, done, 0);
   endtask

   task automatic check_bytes(input string tag);
      int  i;
      rx_t r;
      logic [7:0] e;
      check({tag, " byte count"}, rx_q.size() - rd_ptr, exp_q.size());
      i = 0;
      while (exp_q.size() > 0 && rd_ptr < rx_q.size()) begin
         e = exp_q.pop_front();
         r = rx_q[rd_ptr];
         rd_ptr++;
         check($sformatf("%s byte%0d data", tag, i), r.data, e);
         check($sformatf("%s byte%0d framing", tag, i), {r.start, r.stop}, 32'd1);
`ifdef RTC_UART_PARITY_EN
         check($sformatf("%s byte%0d parity", tag, i), r.par, ^e);
`endif
         i++;
      end
      exp_q.delete();
   endtask

   initial begin
      int low;
      int d0;
      int n_rx;

      // Reset state
      repeat (3) tick();
      check("reset txd", txd, 1);
      check("reset busy", busy, 0);
      check("reset done", done, 0);
      rst = 1'b1;
      tick();

      // Default-parameter bit time: 434 clocks of start bit, then LSB of '1'
      set_digits(1, 2, 3, 4, 5, 6);
      send_def = 1'b1;
      tick();
      send_def = 1'b0;
      check("def start txd", txd_def, 0);
      check("def start busy", busy_def, 1);
      low = 0;
      while (txd_def === 1'b0 && low < 1000) begin
         low++;
         tick();
      end
      check("def start bit clocks", low, 434);
      check("def first data bit", txd_def, 1);

      // Line 1: digits 1..6, start-bit timing and full byte sequence
      send_line(1, 2, 3, 4, 5, 6);
      check("t1 start txd", txd, 0);
      check("t1 start busy", busy, 1);
      low = 0;
      while (txd === 1'b0 && low < CPB + 5) begin
         low++;
         tick();
      end
      check("t1 start bit clocks", low, CPB);
      check("t1 first data bit", txd, 1);
      d0 = done_count;
      wait_done("t1", low);
      check_bytes("t1");
      check("t1 done pulses", done_count - d0, 1);

      // Line 2: inputs change and send is pulsed mid-line; snapshot must hold
      d0 = done_count;
      send_line(2, 3, 5, 9, 4, 7);
      repeat (LINE / 2) tick();
      set_digits(0, 0, 0, 0, 0, 0);
      send = 1'b1;
      tick();
      send = 1'b0;
      wait_done("t3", LINE / 2 + 1);
      check_bytes("t3");
      repeat (LINE / 4) begin
         tick();
         if (busy !== 1'b0) break;
      end
      check("t3 no second line", busy, 0);
      check("t3 done pulses", done_count - d0, 1);
      check("t3 no extra bytes", rx_q.size() - rd_ptr, 0);

      // Line 3: out-of-range digit is sent as '?'
      send_line(0, 10, 0, 0, 0, 0);
      wait_done("t4", 0);
      check_bytes("t4");

      // Reset mid-line: txd/busy react at once, no done, line aborted
      d0 = done_count;
      send_line(1, 2, 3, 4, 5, 6);
      repeat (5000 * CPB / 434) tick();
      rst = 1'b0;
      #1;
      check("t5 abort txd", txd, 1);
      check("t5 abort busy", busy, 0);
      repeat (3) tick();
      check("t5 abort done", done, 0);
      rst = 1'b1;
      tick();
      n_rx = rx_q.size() - rd_ptr;
      check("t5 bytes before abort", n_rx, (5000 * CPB / 434) / (BITS * CPB));
      if (n_rx > 0) check("t5 first byte", rx_q[rd_ptr].data, exp_q[0]);
      rd_ptr = rx_q.size();
      exp_q.delete();
      repeat (2 * CPB) tick();
      check("t5 no done after abort", done_count - d0, 0);
      send_line(1, 2, 3, 4, 5, 6);
      wait_done("t5 relaunch", 0);
      check_bytes("t5 relaunch");

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
